// File: rtl/tape_recorder.sv
// rtl/tape_recorder.sv - cassette port pulse-width decoder that captures tape bytes into a buffer
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   cpu_ce                one-clock enable per CPU cycle (timebase for pulse spacing)
//   io_wr, io_d[7:0]      CPU write to cassette port; io_d[2] motor, io_d[1:0] level
//   ram_we, ram_addr,     one-clock write of a decoded byte into the capture buffer
//   ram_data
//   byte_count            bytes captured since the last motor start
//   recording             latched motor bit
//   overflow              sticky: a completed byte was dropped because the buffer was full
//
// Each bit frame starts with a clock pulse. A second pulse landing inside
// [WIN_LO, WIN_HI] CPU cycles after it makes the bit a 1. Bits arrive MSB first.
module tape_recorder #(
    parameter int               CNT_W   = 12,
    parameter logic [CNT_W-1:0] WIN_LO  = 12'h400,
    parameter logic [CNT_W-1:0] WIN_HI  = 12'h900,
    parameter logic [CNT_W-1:0] TIMEOUT = 12'hFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_ce,
    input  logic        io_wr,
    input  logic [7:0]  io_d,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_data,
    output logic [15:0] byte_count,
    output logic        recording,
    output logic        overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_CLK,
        S_WINDOW,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_ptr_q, bit_ptr_d;
    logic [7:0]       shift_q, shift_d;
    logic             flag_q, flag_d;
    logic             motor_q;
    logic [1:0]       level_q;

    logic [15:0]      addr_q;
    logic [15:0]      count_q;
    logic             full_q;
    logic             overflow_q;
    logic             we_q;
    logic [7:0]       data_q;

    logic             pulse;
    logic             motor_start;
    logic             motor_stop;
    logic             commit;
    logic             byte_done;
    logic             full_now;
    logic             unused_io;

    assign unused_io = &{1'b0, io_d[7:3]};

    // A pulse is a rising edge of the output level away from 00 while the motor runs.
    assign pulse       = io_wr && (io_d[1:0] != 2'b00) && (level_q == 2'b00) && motor_q;
    assign motor_start = io_wr && !motor_q && io_d[2];
    assign motor_stop  = io_wr && motor_q && !io_d[2];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_ptr_d = bit_ptr_q;
        shift_d   = shift_q;
        flag_d    = flag_q;
        commit    = 1'b0;
        byte_done = 1'b0;

        // Motor changes win over anything the frame timing would do this clock.
        if (motor_stop) begin
            state_d   = S_IDLE;
            bit_ptr_d = 3'd7;
            shift_d   = '0;
            flag_d    = 1'b0;
        end else if (motor_start) begin
            state_d   = S_WAIT_CLK;
            cnt_d     = '0;
            bit_ptr_d = 3'd7;
            shift_d   = '0;
            flag_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                end
                S_WAIT_CLK: begin
                    if (pulse) begin
                        cnt_d   = '0;
                        flag_d  = 1'b0;
                        state_d = S_WINDOW;
                    end
                end
                S_WINDOW: begin
                    // Only the first in-window pulse matters; later ones re-set the same flag.
                    if (pulse && (cnt_q >= WIN_LO)) begin
                        flag_d = 1'b1;
                    end
                    if (cpu_ce) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == WIN_HI) begin
                            commit  = 1'b1;
                            state_d = S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (pulse) begin
                        cnt_d   = '0;
                        flag_d  = 1'b0;
                        state_d = S_WINDOW;
                    end else if (cpu_ce) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_d == TIMEOUT) begin
                            state_d   = S_WAIT_CLK;
                            bit_ptr_d = 3'd7;
                            shift_d   = '0;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // flag_d already includes a data pulse arriving on the commit clock.
            if (commit) begin
                shift_d[bit_ptr_q] = flag_d;
                if (bit_ptr_q == 3'd0) begin
                    byte_done = 1'b1;
                    bit_ptr_d = 3'd7;
                end else begin
                    bit_ptr_d = bit_ptr_q - 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_ptr_q <= 3'd7;
            shift_q   <= '0;
            flag_q    <= 1'b0;
            motor_q   <= 1'b0;
            level_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_ptr_q <= bit_ptr_d;
            shift_q   <= shift_d;
            flag_q    <= flag_d;
            if (io_wr) begin
                motor_q <= io_d[2];
                level_q <= io_d[1:0];
            end
        end
    end

    // Also treat the buffer as full on the clock its last slot is being written.
    assign full_now = full_q || (we_q && (addr_q == 16'hFFFF));

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            we_q       <= 1'b0;
            data_q     <= '0;
        end else begin
            we_q <= 1'b0;
            if (motor_start) begin
                addr_q     <= '0;
                count_q    <= '0;
                full_q     <= 1'b0;
                overflow_q <= 1'b0;
            end else if (we_q) begin
                // The last slot is written once; the pointer then parks there.
                if (addr_q == 16'hFFFF) begin
                    full_q <= 1'b1;
                end else begin
                    addr_q  <= addr_q + 16'd1;
                    count_q <= count_q + 16'd1;
                end
            end
            if (byte_done) begin
                if (full_now) begin
                    overflow_q <= 1'b1;
                end else begin
                    we_q   <= 1'b1;
                    data_q <= shift_d;
                end
            end
        end
    end

    assign ram_we     = we_q;
    assign ram_addr   = addr_q;
    assign ram_data   = data_q;
    assign byte_count = count_q;
    assign recording  = motor_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/tape_recorder.md
TAPE_RECORDER -- requirements
Module: tape_recorder

Interface
REQ-001 Parameter CNT_W, default 12, width of the CPU-cycle interval counter.
REQ-002 Parameter WIN_LO, default 12'h400, first count of the data-pulse window.
REQ-003 Parameter WIN_HI, default 12'h900, last count of the data-pulse window.
REQ-004 Parameter TIMEOUT, default 12'hFFF, count at which a bit frame is abandoned.
REQ-005 clock  input  1  single system clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 cpu_ce  input  1  one-clock CPU cycle enable, one pulse per CPU cycle at any CPU speed.
REQ-008 io_wr  input  1  one-clock strobe: CPU write to cassette port $FF.
REQ-009 io_d  input  8  data byte of that write; [2] motor, [1:0] output level.
REQ-010 ram_we  output  1  one-clock write strobe into the tape capture buffer.
REQ-011 ram_addr  output  16  buffer address for ram_we.
REQ-012 ram_data  output  8  decoded byte for ram_we.
REQ-013 byte_count  output  16  bytes captured since the last motor start.
REQ-014 recording  output  1  high while the motor is on.
REQ-015 overflow  output  1  sticky: a byte was dropped because the buffer was full.

Function
REQ-016 Latches motor and level on every io_wr; a pulse is an io_wr with io_d[1:0] != 00 while the latched level is 00 and the motor is on.
REQ-017 Motor start (latched motor 0, io_d[2]=1): clears ram_addr, byte_count, overflow, and the shift register; sets bit pointer to 7; enters WAIT_CLK.
REQ-018 Motor stop (latched motor 1, io_d[2]=0): enters IDLE and discards any partial byte.
REQ-019 States: IDLE (motor off), WAIT_CLK (awaiting clock pulse), WINDOW (count <= WIN_HI after clock pulse), GAP (bit committed, awaiting next clock pulse).
REQ-020 Counter clears to 0 on a clock pulse and increments on each cpu_ce in WINDOW/GAP; it saturates at TIMEOUT.
REQ-021 WAIT_CLK, pulse: treated as a clock pulse; clears the data flag; enters WINDOW.
REQ-022 WINDOW, pulse at count < WIN_LO: ignored.
REQ-023 WINDOW, pulse at WIN_LO <= count <= WIN_HI: sets the data flag; further pulses in the window are ignored.
REQ-024 WINDOW, count reaching WIN_HI+1: commits bit (flag) at bit pointer, MSB first; enters GAP.
REQ-025 GAP, pulse: treated as a new clock pulse (REQ-021).
REQ-026 GAP, count reaching TIMEOUT: discards the partial byte; sets bit pointer to 7; enters WAIT_CLK.
REQ-027 Commit of bit 0 completes a byte: next clock ram_we=1 for exactly one clock, with ram_data=byte and ram_addr=current pointer; then pointer and byte_count increment; bit pointer returns to 7.
REQ-028 Full buffer: after a write at ram_addr 16'hFFFF, pointer and byte_count hold; later completed bytes produce no ram_we and set overflow.
REQ-029 An io_wr in the same clock as a bit commit takes priority; a motor stop in that clock suppresses the commit and any ram_we.
REQ-030 recording equals the latched motor bit.
REQ-031 io_wr with the motor bit unchanged and the level unchanged has no effect on state.

Reset
REQ-032 reset=1: ram_we=0, ram_addr=0, ram_data=0, byte_count=0, recording=0, overflow=0, state IDLE, counter 0, bit pointer 7, latched level 00.
REQ-033 reset overrides all other inputs in the same clock, including a pending ram_we.

Verification
REQ-034 Motor on (io_d=04), then 8 frames of clock pulse + data pulse at count 12'h600 -> one ram_we, ram_data=FF, ram_addr=0, byte_count=1.
REQ-035 Clock pulses only, no data pulses, for 8 frames -> ram_data=00; pulses at count 12'h100 inside WINDOW -> ignored.
REQ-036 Bits 1,0,1,0,0,1,0,1 -> ram_data=A5; second byte written at ram_addr=1.
REQ-037 Motor stop after 5 bits, then motor start and 8 full bits -> single ram_we at ram_addr=0; the first partial byte never written.
REQ-038 Clock pulse followed by no activity for 12'hFFF cpu_ce -> state WAIT_CLK, no ram_we; next clock pulse starts a fresh byte.
REQ-039 Pointer forced to FFFF, two more bytes -> write at FFFF, second byte dropped, overflow=1; reset mid-frame -> all outputs at REQ-032 values.
